// File: rtl/pb_pkg.sv
// Shared types for the push-button debouncer: the per-channel qualification
// state machine encoding.
package pb_pkg;

  // Two stable levels plus one qualifying state per direction of change.
  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b10,
    S_FALL = 2'b11
  } db_state_t;

endpackage : pb_pkg

// File: rtl/pb_debounce_ch.sv
// One debounce channel: two-flop synchroniser for the raw button line, then a
// stable-level FSM with a counter that accepts a new level only after the
// synchronised input has held it for CNT_MAX consecutive clocks.
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int CNT_MAX = 100000,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic pb_db,
  output logic pb_bouncing
);

  // The qualification window ends when the counter reaches this value, so
  // the counter never needs to represent CNT_MAX itself and cannot wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             sync0_q;
  logic             sync1_q;
  logic             pb_sync;
  db_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pb_db_q, pb_db_d;

  // Bring the asynchronous button line into the clock domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= pb_raw;
      sync1_q <= sync0_q;
    end
  end

  assign pb_sync = sync1_q;

  // State, qualification counter and debounced level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      pb_db_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pb_db_q <= pb_db_d;
    end
  end

  // Next state: any reversal during qualification falls back to the stable
  // state with a cleared count, so partial counts are never reused.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    pb_db_d = pb_db_q;
    case (state_q)
      S_LOW: begin
        if (pb_sync) begin
          state_d = S_RISE;
        end
      end
      S_RISE: begin
        if (!pb_sync) begin
          state_d = S_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          pb_db_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!pb_sync) begin
          state_d = S_FALL;
        end
      end
      S_FALL: begin
        if (pb_sync) begin
          state_d = S_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          pb_db_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        pb_db_d = 1'b0;
      end
    endcase
  end

  assign pb_db       = pb_db_q;
  assign pb_bouncing = (state_q == S_RISE) || (state_q == S_FALL);

endmodule : pb_debounce_ch

// File: rtl/pb_debounce.sv
// Push-button debouncer for a bank of WIDTH independent buttons. Each channel
// is synchronised and qualified separately; pb_db feeds the one-pulse stage.
module pb_debounce
  import pb_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int CNT_MAX = 100000,
  parameter int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pb_raw,
  output logic [WIDTH-1:0] pb_db,
  output logic [WIDTH-1:0] pb_bouncing
);

  // A zero-length qualification window would make the counter meaningless.
  if (CNT_MAX < 1) begin : g_bad_cnt_max
    $error("pb_debounce: CNT_MAX must be at least 1");
  end

  // One fully independent debounce channel per button.
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pb_debounce_ch #(
      .CNT_MAX (CNT_MAX),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .pb_raw      (pb_raw[i]),
      .pb_db       (pb_db[i]),
      .pb_bouncing (pb_bouncing[i])
    );
  end

endmodule : pb_debounce
